// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC accumulator slice.
// No logic; no latency.
// No flow control of its own.
package mac_pkg;

    localparam int ACC_W_DEF = 12;
    localparam int TERMS_DEF = 4;
    localparam int PROD_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add.sv
// Saturating add of an 8-bit product into an ACC_W-bit accumulator.
// Purely combinational, zero latency.
// No flow control; ovf flags that the result was clamped.
module sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  s,
    output logic              ovf
);

    logic [ACC_W:0] wide;

    always_comb begin
        wide = {1'b0, a} + (ACC_W+1)'(b);
        ovf  = wide[ACC_W];
        s    = ovf ? '1 : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates a frame of 8-bit products into a saturating ACC_W-bit sum.
// Latency: sum_valid rises the cycle after the final term is accepted.
// Backpressure: prod_ready drops while a result waits for sum_ready (one bubble per frame).
module mac_accumulator
    import mac_pkg::*;
#(
    parameter  int ACC_W = ACC_W_DEF,
    parameter  int TERMS = TERMS_DEF,
    localparam int CNT_W = $clog2(TERMS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PROD_W-1:0]  prod,
    input  logic               prod_valid,
    input  logic               prod_last,
    output logic               prod_ready,
    output logic [ACC_W-1:0]   sum,
    output logic               sum_ovf,
    output logic [CNT_W-1:0]   term_cnt,
    output logic               sum_valid,
    input  logic               sum_ready
);

    localparam logic [CNT_W-1:0] TERMS_C = CNT_W'(TERMS);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             rdy_q;
    logic             sv_q;

    logic [ACC_W-1:0] add_s;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_nxt;
    logic             xfer;

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (prod),
        .s   (add_s),
        .ovf (add_ovf)
    );

    assign xfer    = prod_valid & rdy_q;
    assign cnt_nxt = cnt + CNT_W'(1);

    // Handshake outputs are registered copies of "next state is / is not DONE".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            rdy_q <= 1'b0;
            sv_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    sv_q  <= 1'b0;
                    if (xfer) begin
                        acc <= ACC_W'(prod);
                        cnt <= CNT_W'(1);
                        ovf <= 1'b0;
                        if (prod_last || TERMS == 1) begin
                            state <= DONE;
                            rdy_q <= 1'b0;
                            sv_q  <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc <= add_s;
                        cnt <= cnt_nxt;
                        ovf <= ovf | add_ovf;
                        if (prod_last || cnt_nxt == TERMS_C) begin
                            state <= DONE;
                            rdy_q <= 1'b0;
                            sv_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        state <= IDLE;
                        rdy_q <= 1'b1;
                        sv_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b0;
                    sv_q  <= 1'b0;
                end
            endcase
        end
    end

    // Result fields come straight from the accumulator flops; they only move on a transfer.
    assign prod_ready = rdy_q;
    assign sum_valid  = sv_q;
    assign sum        = acc;
    assign sum_ovf    = ovf;
    assign term_cnt   = cnt;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three parameterisations driven from item queues.
// Expected frame results come from a plain-arithmetic frame model.
// Random valid gaps and sum_ready stalls exercise both handshakes.
module tb_mac_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] prod_i[3];
    logic       pv[3];
    logic       pl[3];
    logic       sr[3];

    wire [11:0] sum0;
    wire [9:0]  sum1;
    wire [11:0] sum2;
    wire [2:0]  tc0;
    wire [3:0]  tc1;
    wire [0:0]  tc2;
    wire        rdy0, rdy1, rdy2;
    wire        sv0, sv1, sv2;
    wire        ovf0, ovf1, ovf2;

    logic [31:0] sum_a[3];
    logic [31:0] tc_a[3];
    logic        rdy_a[3];
    logic        sv_a[3];
    logic        ovf_a[3];

    assign sum_a[0] = 32'(sum0);
    assign sum_a[1] = 32'(sum1);
    assign sum_a[2] = 32'(sum2);
    assign tc_a[0]  = 32'(tc0);
    assign tc_a[1]  = 32'(tc1);
    assign tc_a[2]  = 32'(tc2);
    assign rdy_a[0] = rdy0;
    assign rdy_a[1] = rdy1;
    assign rdy_a[2] = rdy2;
    assign sv_a[0]  = sv0;
    assign sv_a[1]  = sv1;
    assign sv_a[2]  = sv2;
    assign ovf_a[0] = ovf0;
    assign ovf_a[1] = ovf1;
    assign ovf_a[2] = ovf2;

    mac_accumulator #(.ACC_W(12), .TERMS(4)) u_dut_a (
        .clk(clk), .rst(rst), .prod(prod_i[0]), .prod_valid(pv[0]), .prod_last(pl[0]),
        .prod_ready(rdy0), .sum(sum0), .sum_ovf(ovf0), .term_cnt(tc0),
        .sum_valid(sv0), .sum_ready(sr[0])
    );
    mac_accumulator #(.ACC_W(10), .TERMS(8)) u_dut_b (
        .clk(clk), .rst(rst), .prod(prod_i[1]), .prod_valid(pv[1]), .prod_last(pl[1]),
        .prod_ready(rdy1), .sum(sum1), .sum_ovf(ovf1), .term_cnt(tc1),
        .sum_valid(sv1), .sum_ready(sr[1])
    );
    mac_accumulator #(.ACC_W(12), .TERMS(1)) u_dut_c (
        .clk(clk), .rst(rst), .prod(prod_i[2]), .prod_valid(pv[2]), .prod_last(pl[2]),
        .prod_ready(rdy2), .sum(sum2), .sum_ovf(ovf2), .term_cnt(tc2),
        .sum_valid(sv2), .sum_ready(sr[2])
    );

    int acc_w_p[3] = '{12, 10, 12};
    int terms_p[3] = '{4, 8, 1};

    typedef struct {
        longint sum;
        longint ovf;
        longint cnt;
    } res_t;

    logic [7:0] it_prod[$];
    bit         it_last[$];
    bit         it_end[$];
    res_t       exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic add_item(input int p, input bit l);
        it_prod.push_back(8'(p));
        it_last.push_back(l);
    endtask

    task automatic clear_items();
        it_prod.delete();
        it_last.delete();
    endtask

    // Frame model: a frame closes on prod_last or on reaching TERMS products;
    // a saturating sum of non-negative terms is simply min(total, max).
    function automatic void build_model(input int d);
        longint total = 0;
        longint n     = 0;
        longint maxv  = (longint'(1) << acc_w_p[d]) - 1;
        res_t   r;
        it_end.delete();
        exp_q.delete();
        for (int i = 0; i < it_prod.size(); i++) begin
            total += longint'(it_prod[i]);
            n++;
            if (it_last[i] || n == longint'(terms_p[d])) begin
                r.sum = (total > maxv) ? maxv : total;
                r.ovf = (total > maxv) ? 1 : 0;
                r.cnt = n;
                exp_q.push_back(r);
                it_end.push_back(1'b1);
                total = 0;
                n     = 0;
            end else begin
                it_end.push_back(1'b0);
            end
        end
    endfunction

    task automatic run_stream(input int d, input bit rnd);
        int idx       = 0;
        int ri        = 0;
        int cyc       = 0;
        bit took_item = 1'b0;
        build_model(d);
        while (ri < exp_q.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (took_item) begin
                check("sum_valid_latency", 64'(sv_a[d]), 64'(it_end[idx]));
                idx++;
            end
            if (idx < it_prod.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
                pv[d]     = 1'b1;
                prod_i[d] = it_prod[idx];
                pl[d]     = it_last[idx];
            end else begin
                pv[d]     = 1'b0;
                prod_i[d] = 8'($urandom);
                pl[d]     = 1'($urandom);
            end
            sr[d]     = !rnd || ($urandom_range(0, 2) != 0);
            took_item = pv[d] && rdy_a[d];
            if (sv_a[d]) begin
                check("ready_low_in_done", 64'(rdy_a[d]), 64'd0);
                if (sr[d]) begin
                    check("sum", 64'(sum_a[d]), 64'(exp_q[ri].sum));
                    check("sum_ovf", 64'(ovf_a[d]), 64'(exp_q[ri].ovf));
                    check("term_cnt", 64'(tc_a[d]), 64'(exp_q[ri].cnt));
                    ri++;
                end
            end
        end
        check("frames_completed", 64'(ri), 64'(exp_q.size()));
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            prod_i[d] = 8'd0;
            pv[d]     = 1'b0;
            pl[d]     = 1'b0;
            sr[d]     = 1'b1;
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            check("rst_sum", 64'(sum_a[d]), 64'd0);
            check("rst_sum_valid", 64'(sv_a[d]), 64'd0);
            check("rst_prod_ready", 64'(rdy_a[d]), 64'd0);
            check("rst_term_cnt", 64'(tc_a[d]), 64'd0);
            check("rst_sum_ovf", 64'(ovf_a[d]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", 64'(rdy_a[0]), 64'd1);

        // Four 225s with no prod_last: TERMS closes the frame.
        clear_items();
        for (int i = 0; i < 4; i++) add_item(225, 1'b0);
        run_stream(0, 1'b0);

        // Five 225s into a 10-bit accumulator: saturates.
        clear_items();
        for (int i = 0; i < 5; i++) add_item(225, i == 4);
        run_stream(1, 1'b0);

        // 6 + 7 then a fresh single-term frame.
        clear_items();
        add_item(6, 1'b0);
        add_item(7, 1'b1);
        add_item(5, 1'b1);
        run_stream(0, 1'b0);

        // TERMS=1: every product is its own frame.
        clear_items();
        add_item(9, 1'b0);
        add_item(200, 1'b0);
        run_stream(2, 1'b0);

        // Stall the result for five cycles while offering more products.
        @(negedge clk);
        pv[0] = 1'b1; prod_i[0] = 8'd1; pl[0] = 1'b0; sr[0] = 1'b0;
        @(negedge clk);
        prod_i[0] = 8'd2; pl[0] = 1'b1;
        @(negedge clk);
        prod_i[0] = 8'd50; pl[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_sum_valid", 64'(sv_a[0]), 64'd1);
            check("stall_sum", 64'(sum_a[0]), 64'd3);
            check("stall_term_cnt", 64'(tc_a[0]), 64'd2);
            check("stall_prod_ready", 64'(rdy_a[0]), 64'd0);
            @(negedge clk);
        end
        sr[0] = 1'b1;
        @(negedge clk);
        check("post_handoff_valid", 64'(sv_a[0]), 64'd0);
        check("post_handoff_ready", 64'(rdy_a[0]), 64'd1);
        pv[0] = 1'b0;
        clear_items();
        add_item(4, 1'b1);
        run_stream(0, 1'b0);

        // Reset mid-frame after two of four terms.
        @(negedge clk);
        pv[0] = 1'b1; prod_i[0] = 8'd1; pl[0] = 1'b0;
        @(negedge clk);
        prod_i[0] = 8'd2;
        @(negedge clk);
        pv[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_sum_valid", 64'(sv_a[0]), 64'd0);
        check("midrst_sum", 64'(sum_a[0]), 64'd0);
        check("midrst_term_cnt", 64'(tc_a[0]), 64'd0);
        check("midrst_prod_ready", 64'(rdy_a[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_items();
        for (int i = 1; i <= 4; i++) add_item(i, 1'b0);
        run_stream(0, 1'b0);

        // Randomised frames on every configuration.
        for (int d = 0; d < 3; d++) begin
            clear_items();
            for (int i = 0; i < 40; i++) begin
                add_item((d == 1) ? $urandom_range(150, 255) : $urandom_range(0, 255),
                         (i == 39) || ($urandom_range(0, 3) == 0));
            end
            run_stream(d, 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12: accumulator/result width in bits, legal range 8..32.
REQ-002 SHALL have parameter TERMS, default 4: maximum products per frame, legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; reset is asynchronous and active-high.
REQ-005 SHALL have port prod, input, 8: unsigned 8-bit product from the 4x4 multiplier output o[7:0].
REQ-006 SHALL have port prod_valid, input, 1: prod is valid this cycle.
REQ-007 SHALL have port prod_last, input, 1: qualified by prod_valid; marks the final term of a frame.
REQ-008 SHALL have port prod_ready, output, 1: block accepts prod this cycle.
REQ-009 SHALL have port sum, output, ACC_W: accumulated frame result, unsigned.
REQ-010 SHALL have port sum_ovf, output, 1: frame saturated.
REQ-011 SHALL have port term_cnt, output, $clog2(TERMS+1): number of terms in the frame.
REQ-012 SHALL have port sum_valid, output, 1: sum/sum_ovf/term_cnt are valid.
REQ-013 SHALL have port sum_ready, input, 1: consumer accepts the result.

Function
REQ-014 SHALL treat a transfer as prod_valid & prod_ready, and a result handoff as sum_valid & sum_ready, both on the same rising edge.
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-016 SHALL drive prod_ready=1 in IDLE and ACCUM and 0 in DONE; sum_valid=1 only in DONE.
REQ-017 IDLE on transfer SHALL set acc<=zero-extended prod, cnt<=1, ovf<=0; next state DONE if prod_last or TERMS==1, else ACCUM.
REQ-018 ACCUM on transfer SHALL set acc<=sat(acc+prod), cnt<=cnt+1, ovf<=ovf | carry; next state DONE if prod_last or cnt+1==TERMS, else stay.
REQ-019 sat(): when the ACC_W+1-bit sum exceeds 2^ACC_W-1 the result SHALL be 2^ACC_W-1; ovf is sticky for the frame.
REQ-020 DONE SHALL hold sum=acc, sum_ovf=ovf, term_cnt=cnt stable until handoff, then go to IDLE.
REQ-021 Latency: sum_valid SHALL assert on the cycle after the edge that accepts the final term; one bubble cycle per frame.
REQ-022 No transfer cycle in IDLE/ACCUM SHALL leave all state unchanged; prod_last without prod_valid SHALL be ignored.
REQ-023 In DONE, prod_valid SHALL be ignored (not accepted) regardless of prod_last.
REQ-024 Outputs sum, sum_ovf, term_cnt SHALL be registered; no combinational path from prod to sum.

Reset
REQ-025 On rst high: state=IDLE, acc=0, cnt=0, ovf=0, sum_valid=0, sum=0, sum_ovf=0, term_cnt=0, immediately, regardless of clk.
REQ-026 prod_ready SHALL be 0 while rst is high and follow REQ-016 from the first edge after release.
REQ-027 Reset mid-frame or in DONE SHALL discard the partial/pending result with no output handoff.

Structure
REQ-028 Shared package mac_pkg SHALL hold the state enum (IDLE/ACCUM/DONE), the default ACC_W/TERMS constants and the product width constant (8).
REQ-029 Saturating add SHALL be a sub-module sat_add (inputs ACC_W-bit a, 8-bit b; outputs ACC_W-bit s, 1-bit ovf), purely combinational.

Verification
REQ-030 ACC_W=12, TERMS=4, four products of 225 back-to-back, sum_ready=1 -> sum=900, sum_ovf=0, term_cnt=4, sum_valid one cycle after 4th accept.
REQ-031 ACC_W=10, TERMS=8, five 225s, last on 5th -> sum=1023, sum_ovf=1, term_cnt=5.
REQ-032 Products 6 then 7 with prod_last on 7 -> sum=13, term_cnt=2; following frame starts clean (ovf=0, cnt=1 after first term).
REQ-033 sum_ready=0 for 5 cycles in DONE with prod_valid=1 -> sum stable, prod_ready=0, nothing accepted; handoff then IDLE.
REQ-034 rst pulsed after 2 of 4 terms -> no sum_valid; next frame of 1,2,3,4 yields sum=10, term_cnt=4.
REQ-035 TERMS=1, products 9 and 200 -> two frames, sum=9 then 200, each term_cnt=1.
